// File: rtl/issue_ctrl_pkg.sv
// Shared constants and FSM encoding for the instruction issue controller.
// The ISSUE_RETIRE_CNT_EN option is handled in instr_issue_ctrl.sv.
package issue_ctrl_pkg;

    localparam logic [31:0] NOP_WORD = 32'h00000013;  // addi zero, zero, 0

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } issue_state_t;

endpackage

// File: rtl/issue_fifo.sv
// Circular instruction buffer with head/tail pointers and registered occupancy.
// The pointers wrap naturally because DEPTH is a power of two.
module issue_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   head_data,
    output logic [CW-1:0] count
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push   = push && (count != CW'(DEPTH)) && !clear;
    assign do_pop    = pop && (count != '0) && !clear;
    assign head_data = mem[head];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue controller feeding a single-cycle core: buffers pushed words and issues one per
// cycle under start/stop/flush, NOP otherwise. `define ISSUE_RETIRE_CNT_EN adds retired_cnt.
module instr_issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP_WORD,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    input  logic          start,
    input  logic          stop,
    input  logic          flush,
    output logic [31:0]   instruction,
    output logic          issued,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          done,
`ifdef ISSUE_RETIRE_CNT_EN
    output logic [31:0]   retired_cnt,
`endif
    output issue_state_t  fsm_state
);

    issue_state_t state;
    issue_state_t state_next;
    logic         do_issue;
    logic         push;
    logic         done_next;
    logic [31:0]  head_data;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on registered occupancy and flush, never on in_valid.
    assign push      = in_valid && in_ready;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign fsm_state = state;

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (in_instr),
        .pop       (do_issue),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= HALT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = HALT;
        end else begin
            case (state)
                HALT:    if (start) state_next = RUN;
                RUN:     if (stop)  state_next = DRAIN;
                DRAIN: begin
                    if (start)             state_next = RUN;
                    else if (count == '0)  state_next = HALT;
                end
                default: state_next = HALT;
            endcase
        end
    end

    always_comb begin
        in_ready  = !full && !flush;
        do_issue  = (state != HALT) && (count != '0) && !flush;
        done_next = (state == DRAIN) && !flush && !start && (count == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            issued      <= 1'b0;
            done        <= 1'b0;
        end else begin
            instruction <= do_issue ? head_data : NOP_INSTR;
            issued      <= do_issue;
            done        <= done_next;
        end
    end

`ifdef ISSUE_RETIRE_CNT_EN
    // Survives flush on purpose; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        retired_cnt <= '0;
        else if (do_issue) retired_cnt <= retired_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench for instr_issue_ctrl: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_instr_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_instr = '0;
    logic          in_ready;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          flush = 1'b0;
    logic [31:0]   instruction;
    logic          issued;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          done;
`ifdef ISSUE_RETIRE_CNT_EN
    logic [31:0]   retired_cnt;
`endif
    issue_state_t  fsm_state;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    instr_issue_ctrl #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .start       (start),
        .stop        (stop),
        .flush       (flush),
        .instruction (instruction),
        .issued      (issued),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .done        (done),
`ifdef ISSUE_RETIRE_CNT_EN
        .retired_cnt (retired_cnt),
`endif
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO contents as a plain queue, mode 0=halt 1=run 2=drain
    logic [31:0] exp_q[$];
    int          m_mode    = 0;
    logic [31:0] m_instr   = NOP;
    logic        m_issued  = 1'b0;
    logic        m_done    = 1'b0;
    logic [31:0] m_retired = '0;

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                exp_q.delete();
                m_mode = 0; m_instr = NOP; m_issued = 1'b0; m_done = 1'b0; m_retired = '0;
            end else begin : model_step
                bit          iss;
                bit          acc;
                int          nmode;
                logic [31:0] w;
                w     = NOP;
                iss   = (m_mode != 0) && (exp_q.size() > 0) && !flush;
                acc   = in_valid && !flush && (exp_q.size() < DEPTH);
                m_done = (m_mode == 2) && !flush && !start && (exp_q.size() == 0);
                if (flush)                            nmode = 0;
                else if (m_mode == 0)                 nmode = start ? 1 : 0;
                else if (m_mode == 1)                 nmode = stop ? 2 : 1;
                else if (start)                       nmode = 1;
                else                                  nmode = (exp_q.size() == 0) ? 0 : 2;
                if (flush) exp_q.delete();
                else begin
                    if (iss) w = exp_q.pop_front();
                    if (acc) exp_q.push_back(in_instr);
                end
                m_instr  = iss ? w : NOP;
                m_issued = iss;
                if (iss) m_retired = m_retired + 32'd1;
                m_mode   = nmode;
            end
        end
    end

    // scoreboard compare, every cycle after reset release
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (checking && reset) begin
                chk("instruction", instruction, m_instr);
                chk("issued", 32'(issued), 32'(m_issued));
                chk("count", 32'(count), exp_q.size());
                chk("empty", 32'(empty), 32'(exp_q.size() == 0));
                chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
                chk("done", 32'(done), 32'(m_done));
                chk("in_ready", 32'(in_ready), 32'(!flush && exp_q.size() < DEPTH));
                chk("state", 32'(fsm_state), m_mode);
`ifdef ISSUE_RETIRE_CNT_EN
                chk("retired_cnt", retired_cnt, m_retired);
`endif
            end
        end
    end

    // driver tasks
    task automatic push4(input logic [31:0] w0, w1, w2, w3);
        logic [31:0] ws [4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_instr = ws[i];
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic drain_to_halt();
        @(negedge clock); stop = 1'b1;
        @(negedge clock); stop = 1'b0;
        repeat (DEPTH + 3) @(negedge clock);
    endtask

    initial begin
        logic [31:0] words [4];
        int          dones;
        words[0] = 32'h00100593; words[1] = 32'h00200613;
        words[2] = 32'h00500693; words[3] = 32'h00600713;

        // reset values while reset is held
        repeat (2) @(negedge clock);
        chk("rst_instruction", instruction, NOP);
        chk("rst_issued", 32'(issued), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b1;
        checking = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 1);

        // fill in HALT: buffer full, nothing issued
        push4(words[0], words[1], words[2], words[3]);
        #1;
        chk("halt_full", 32'(full), 1);
        chk("halt_in_ready", 32'(in_ready), 0);
        chk("halt_instruction", instruction, NOP);
        chk("halt_issued", 32'(issued), 0);

        // start: four words on consecutive cycles, then NOP
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #3;
            chk("run_order", instruction, words[i]);
            chk("run_issued", 32'(issued), 1);
        end
        @(posedge clock); #3;
        chk("run_tail_nop", instruction, NOP);
        drain_to_halt();

        // stop with count=2: both issue, then one done pulse
        push4(32'h00a00093, 32'h00b00113, 32'h00c00193, 32'h00d00213);
        pulse_start();
        @(negedge clock);
        @(negedge clock);
        #1 chk("stop_count_before", 32'(count), 2);
        stop = 1'b1;
        @(negedge clock); stop = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #3;
            if (done) dones++;
        end
        chk("done_pulses", dones, 1);
        chk("stop_count_after", 32'(count), 0);
        chk("stop_state", 32'(fsm_state), 32'(HALT));

        // full buffer refuses a push in a popping cycle, then accepts on retry
        push4(words[0], words[1], words[2], words[3]);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0; in_valid = 1'b1; in_instr = 32'h00c58833;
        @(negedge clock);
        #1 chk("wrap_refused_count", 32'(count), 3);
        @(negedge clock); in_valid = 1'b0;
        #1 chk("wrap_after_retry_count", 32'(count), 3);
        repeat (6) @(negedge clock);
        drain_to_halt();

        // flush with count=3 in RUN while in_valid=1
        push4(words[3], words[2], words[1], words[0]);
        pulse_start();
        @(negedge clock);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00f00293;
        #1 chk("flush_in_ready", 32'(in_ready), 0);
        @(posedge clock); #3;
        chk("flush_count", 32'(count), 0);
        chk("flush_instruction", instruction, NOP);
        chk("flush_issued", 32'(issued), 0);
        chk("flush_done", 32'(done), 0);
        chk("flush_state", 32'(fsm_state), 32'(HALT));
        @(negedge clock); flush = 1'b0; in_valid = 1'b0;

        // random traffic with one asynchronous reset in the middle
        for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = $urandom;
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 11) == 0);
            flush    = ($urandom_range(0, 29) == 0);
            if (c == 400) begin
                start = 1'b0; stop = 1'b0; flush = 1'b0;
                #2 reset = 1'b0;
                #1;
                chk("async_rst_instruction", instruction, NOP);
                chk("async_rst_issued", 32'(issued), 0);
                chk("async_rst_count", 32'(count), 0);
`ifdef ISSUE_RETIRE_CNT_EN
                chk("async_rst_retired", retired_cnt, 0);
`endif
                @(negedge clock);
                reset = 1'b1;
            end
        end
        @(negedge clock);
        in_valid = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
